instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_timer.sv | 40 ++++
 rtl/instr_fetch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, halt opcode encodings and datapath widths.
// FETCH_BUS_TIMEOUT_EN adds the ERR state used by the bus-timeout option.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  localparam logic [3:0] OPC_HALT       = 4'b1011;
  localparam logic [1:0] OPC_HALT_CLASS = 2'b11;

  typedef enum logic [2:0] {
    ST_REQ1 = 3'd0,
    ST_REQ2 = 3'd1,
    ST_HOLD = 3'd2,
    ST_HALT = 3'd3
`ifdef FETCH_BUS_TIMEOUT_EN
    ,
    ST_ERR  = 3'd4
`endif
  } fetch_state_e;

  // Opcode 1011 and the whole 11xx class retire as a halt.
  function automatic logic is_halt_opc(input logic [3:0] opc);
    return (opc == OPC_HALT) || (opc[3:2] == OPC_HALT_CLASS);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Counts consecutive stalled request cycles and flags the cycle that reaches LIMIT.
// Instantiated by instr_fetch only when FETCH_BUS_TIMEOUT_EN is defined.
module fetch_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'd0;
    end else if (count_en_i) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Expires on the stalled cycle whose increment would reach LIMIT.
  assign expired_o = count_en_i && !clear_i && (count_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Two-byte instruction fetch unit with redirect, halt detection and optional bus timeout.
// Define FETCH_BUS_TIMEOUT_EN to enable the timeout counter and sticky ERR state.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC       = 8'h00,
  parameter int                TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] ir1,
  output logic [DATA_W-1:0] ir2,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir1_q, ir1_d;
  logic [DATA_W-1:0] ir2_q, ir2_d;

`ifdef FETCH_BUS_TIMEOUT_EN
  logic in_req_s;
  logic tmr_clear_s;
  logic timeout_s;

  assign in_req_s    = (state_q == ST_REQ1) || (state_q == ST_REQ2);
  assign tmr_clear_s = !in_req_s || mem_ack || redirect;

  fetch_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_fetch_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (tmr_clear_s),
    .count_en_i(in_req_s),
    .expired_o (timeout_s)
  );
`endif

  // Redirect outranks mem_ack, instr_ready and halt detection in every live state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir1_d   = ir1_q;
    ir2_d   = ir2_q;
    case (state_q)
      ST_REQ1: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ1;
        end else if (mem_ack) begin
          ir1_d   = mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = ST_REQ2;
`ifdef FETCH_BUS_TIMEOUT_EN
        end else if (timeout_s) begin
          state_d = ST_ERR;
`endif
        end else begin
          state_d = ST_REQ1;
        end
      end
      ST_REQ2: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ1;
        end else if (mem_ack) begin
          ir2_d   = mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = ST_HOLD;
`ifdef FETCH_BUS_TIMEOUT_EN
        end else if (timeout_s) begin
          state_d = ST_ERR;
`endif
        end else begin
          state_d = ST_REQ2;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ1;
        end else if (instr_ready) begin
          state_d = is_halt_opc(ir1_q[7:4]) ? ST_HALT : ST_REQ1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALT: state_d = ST_HALT;
`ifdef FETCH_BUS_TIMEOUT_EN
      ST_ERR:  state_d = ST_ERR;
`endif
      default: state_d = ST_REQ1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_REQ1;
      pc_q    <= RESET_PC;
      ir1_q   <= 8'h00;
      ir2_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir1_q   <= ir1_d;
      ir2_q   <= ir2_d;
    end
  end

  // All status outputs decode the state register, so they are glitch-free.
  assign mem_req     = (state_q == ST_REQ1) || (state_q == ST_REQ2);
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign halted      = (state_q == ST_HALT);
  assign ir1         = ir1_q;
  assign ir2         = ir2_q;
  assign opcode      = ir1_q[7:4];
  assign pc          = pc_q;
`ifdef FETCH_BUS_TIMEOUT_EN
  assign fetch_err   = (state_q == ST_ERR);
`else
  assign fetch_err   = 1'b0;
`endif

endmodule
